bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter: NUM_REQ, 4, number of bus requesters (2..8).
REQ-002 Port: clk  input  1  sole clock, rising-edge active.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: req  input  NUM_REQ  per-requester transfer request level, held until its gnt.
REQ-005 Port: req_src  input  NUM_REQ*5  per-requester bus source index, requester i in bits [5i+4:5i].
REQ-006 Port: req_dst  input  NUM_REQ*5  per-requester destination register index, same packing.
REQ-007 Port: bus_select  output  5  source select driven to the registered 32-way bus mux.
REQ-008 Port: bus_contents  input  32  registered bus mux output, monitored only.
REQ-009 Port: dst_load  output  32  one-hot destination load enable.
REQ-010 Port: gnt  output  NUM_REQ  one-hot, single-cycle completion pulse to the served requester.
REQ-011 Port: err  output  1  single-cycle pulse coincident with gnt when the source index is illegal.
REQ-012 Port: busy  output  1  high whenever state is not IDLE.

Function
REQ-013 FSM states: IDLE, SELECT, LOAD; IDLE->SELECT when any req high; SELECT->LOAD unconditionally; LOAD->IDLE unconditionally.
REQ-014 In IDLE with any req high, arbiter latches winner index, its req_src and req_dst, and registers bus_select <= winner req_src on the same edge.
REQ-015 Arbitration is round-robin: search starts at (last winner + 1) mod NUM_REQ; after reset the search starts at requester 0.
REQ-016 SELECT lasts exactly one cycle so the registered mux captures the new select; bus_contents is valid during LOAD.
REQ-017 In LOAD, dst_load[latched dst] = 1 for exactly one cycle and gnt[winner] = 1 in the same cycle.
REQ-018 Fixed latency: req sampled at edge N -> gnt and dst_load high in cycle N+2; one transfer per 3 cycles per back-to-back stream.
REQ-019 Legal source indices are 0-19 and 21-23; index 20 or 24-31 is illegal.
REQ-020 Illegal source: full SELECT/LOAD sequence still runs, dst_load stays all-zero, err pulses with gnt.
REQ-021 src equal to dst is legal and performs the load.
REQ-022 Requests arriving during SELECT/LOAD are not sampled until IDLE; no pre-emption.
REQ-023 Winner dropping req after being sampled does not abort: transfer completes and gnt still pulses.
REQ-024 req_src/req_dst changes after sampling have no effect on the current transfer.
REQ-025 bus_select holds its last value in IDLE; dst_load, gnt, err are zero outside LOAD.
REQ-026 Winner in LOAD and re-requesting is re-arbitrated fairly, never served twice while another requester waits.

Reset
REQ-027 Reset forces state IDLE, bus_select 0, dst_load 0, gnt 0, err 0, busy 0, round-robin pointer to requester 0, immediately and asynchronously.
REQ-028 Reset mid-transfer aborts it: no dst_load or gnt is issued for the aborted request after reset releases unless re-sampled in IDLE.

Structure
REQ-029 Shared package holds: state encoding, BUS_SEL_W = 5, DST_W = 32, and the legal-source mask constant (32-bit, bits 20 and 24-31 clear).
REQ-030 One sub-module rr_arbiter (NUM_REQ requests, pointer input, one-hot winner and index outputs, combinational) is instantiated once.

Verification
REQ-031 Single request: req[0]=1, src=5, dst=12 -> bus_select=5 after edge 1, dst_load=0x00001000 and gnt=0001 in cycle 2, busy high cycles 1-2.
REQ-032 Round-robin: req=1111 held, sources distinct -> gnt order 0,1,2,3,0 at 3-cycle spacing.
REQ-033 Illegal source: req[2]=1, src=20, dst=3 -> dst_load=0, gnt=0100 and err=1 in cycle 2; repeat with src=31 gives the same.
REQ-034 Drop mid-transfer: req[1] asserted one cycle only, src=7, dst=7 -> gnt=0010, dst_load=0x00000080 in cycle 2.
REQ-035 Reset in SELECT: assert reset during SELECT -> all outputs 0 immediately; after release with req=0000 no gnt ever pulses.
REQ-036 Data check with mux model: data_9=0xDEADBEEF, src=9, dst=4 -> bus_contents=0xDEADBEEF in the cycle dst_load=0x00000010.

Source files
------------

// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the bus transfer arbiter: FSM encoding, bus widths
// and the table of source indices that may legally drive the bus.
package bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SELECT = 2'd1,
    ST_LOAD   = 2'd2
  } state_e;

  localparam int BUS_SEL_W = 5;
  localparam int DST_W     = 32;

  // Sources 20 and 24-31 are not wired to real registers on the mux.
  localparam logic [31:0] LEGAL_SRC_MASK = 32'h00EF_FFFF;

  function automatic logic src_is_legal(input logic [BUS_SEL_W-1:0] src);
    return LEGAL_SRC_MASK[src];
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first asserted request at or after
// ptr_i (wrapping) wins.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_oh_o,
  output logic [IDX_W-1:0]   gnt_idx_o,
  output logic               gnt_vld_o
);

  always_comb begin
    int cand;
    cand      = 0;
    gnt_vld_o = 1'b0;
    gnt_idx_o = '0;
    gnt_oh_o  = '0;
    // Walk from farthest to nearest so the nearest hit is the one that sticks.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = (int'(ptr_i) + k) % NUM_REQ;
      if (req_i[cand]) begin
        gnt_vld_o = 1'b1;
        gnt_idx_o = IDX_W'(cand);
      end
    end
    if (gnt_vld_o) begin
      gnt_oh_o[gnt_idx_o] = 1'b1;
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Serves one register-to-register bus transfer per 3 cycles (IDLE/SELECT/LOAD),
// choosing among requesters round-robin; illegal sources complete with err.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*BUS_SEL_W-1:0] req_src,
  input  logic [NUM_REQ*BUS_SEL_W-1:0] req_dst,
  output logic [BUS_SEL_W-1:0]         bus_select,
  input  logic [31:0]                  bus_contents,
  output logic [DST_W-1:0]             dst_load,
  output logic [NUM_REQ-1:0]           gnt,
  output logic                         err,
  output logic                         busy
);

  localparam int IDX_W = $clog2(NUM_REQ);

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [NUM_REQ-1:0]   win_oh_q, win_oh_d;
  logic [BUS_SEL_W-1:0] sel_q, sel_d;
  logic [BUS_SEL_W-1:0] dst_q, dst_d;
  logic                 legal_q, legal_d;

  logic [NUM_REQ-1:0]   arb_oh;
  logic [IDX_W-1:0]     arb_idx;
  logic                 arb_vld;
  logic [BUS_SEL_W-1:0] win_src, win_dst;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req_i     (req),
    .ptr_i     (ptr_q),
    .gnt_oh_o  (arb_oh),
    .gnt_idx_o (arb_idx),
    .gnt_vld_o (arb_vld)
  );

  assign win_src = req_src[int'(arb_idx)*BUS_SEL_W +: BUS_SEL_W];
  assign win_dst = req_dst[int'(arb_idx)*BUS_SEL_W +: BUS_SEL_W];

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    win_oh_d = win_oh_q;
    sel_d    = sel_q;
    dst_d    = dst_q;
    legal_d  = legal_q;
    busy     = (state_q != ST_IDLE);
    gnt      = '0;
    err      = 1'b0;
    dst_load = '0;
    case (state_q)
      ST_IDLE: begin
        // Everything the transfer needs is captured here so the requester
        // may drop or change its inputs afterwards.
        if (arb_vld) begin
          state_d  = ST_SELECT;
          win_oh_d = arb_oh;
          sel_d    = win_src;
          dst_d    = win_dst;
          legal_d  = src_is_legal(win_src);
          ptr_d    = IDX_W'((int'(arb_idx) + 1) % NUM_REQ);
        end
      end
      ST_SELECT: state_d = ST_LOAD;
      ST_LOAD: begin
        state_d = ST_IDLE;
        gnt     = win_oh_q;
        err     = ~legal_q;
        if (legal_q) begin
          dst_load[dst_q] = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      win_oh_q <= '0;
      sel_q    <= '0;
      dst_q    <= '0;
      legal_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      win_oh_q <= win_oh_d;
      sel_q    <= sel_d;
      dst_q    <= dst_d;
      legal_q  <= legal_d;
    end
  end

  assign bus_select = sel_q;

  // The bus data is only observed: a legal load must never latch unknown data.
  a_load_data_known: assert property (@(posedge clk) disable iff (reset)
    (state_q == ST_LOAD && legal_q) |-> !$isunknown(bus_contents));

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios plus random traffic, all checked
// against a transaction-level model and a registered 32-way mux model.
module tb_bus_arbiter;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*5-1:0] req_src = '0;
  logic [N*5-1:0] req_dst = '0;
  logic [4:0]     bus_select;
  logic [31:0]    bus_contents;
  logic [31:0]    dst_load;
  logic [N-1:0]   gnt;
  logic           err;
  logic           busy;

  logic [31:0] mux_data [32];

  int vectors = 0;
  int miscompares = 0;

  int         cyc;
  int         m_next_free, m_start, m_ptr, m_win;
  logic [4:0] m_src, m_dst, m_sel;

  always #5 clk = ~clk;

  always @(posedge clk) bus_contents <= mux_data[bus_select];

  bus_arbiter #(.NUM_REQ(N)) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .req_src      (req_src),
    .req_dst      (req_dst),
    .bus_select   (bus_select),
    .bus_contents (bus_contents),
    .dst_load     (dst_load),
    .gnt          (gnt),
    .err          (err),
    .busy         (busy)
  );

  function automatic logic ref_legal(input logic [4:0] s);
    return !(s == 5'd20 || s >= 5'd24);
  endfunction

  task automatic set_req(input int i, input logic [4:0] s, input logic [4:0] d);
    req_src[i*5 +: 5] = s;
    req_dst[i*5 +: 5] = d;
  endtask

  task automatic model_reset();
    cyc = 0; m_next_free = 0; m_start = -100; m_ptr = 0; m_win = 0;
    m_src = '0; m_dst = '0; m_sel = '0;
  endtask

  // One clock: model decides what the coming edge samples, then all outputs
  // are compared on the following falling edge.
  task automatic tick(input string tag);
    int          e;
    logic        ld, x_busy, x_err;
    logic [N-1:0] x_gnt;
    logic [31:0] x_dst;
    e = cyc + 1;
    if (e >= m_next_free && req != '0) begin
      for (int k = 0; k < N; k++) begin
        if (req[(m_ptr + k) % N]) begin
          m_win = (m_ptr + k) % N;
          break;
        end
      end
      m_src = req_src[m_win*5 +: 5];
      m_dst = req_dst[m_win*5 +: 5];
      m_sel = m_src;
      m_start = e;
      m_next_free = e + 3;
      m_ptr = (m_win + 1) % N;
    end
    @(posedge clk);
    cyc = e;
    @(negedge clk);
    ld = (cyc == m_start + 1);
    x_busy = (cyc == m_start) || ld;
    x_gnt = '0;
    x_dst = '0;
    x_err = 1'b0;
    if (ld) begin
      x_gnt[m_win] = 1'b1;
      if (ref_legal(m_src)) x_dst[m_dst] = 1'b1;
      else x_err = 1'b1;
    end
    vectors++;
    if (bus_select !== m_sel) begin
      miscompares++;
      $display("FAIL %s bus_select cyc=%0d got=%0d want=%0d", tag, cyc, bus_select, m_sel);
    end
    vectors++;
    if (busy !== x_busy) begin
      miscompares++;
      $display("FAIL %s busy cyc=%0d got=%b want=%b", tag, cyc, busy, x_busy);
    end
    vectors++;
    if (gnt !== x_gnt) begin
      miscompares++;
      $display("FAIL %s gnt cyc=%0d got=%b want=%b", tag, cyc, gnt, x_gnt);
    end
    vectors++;
    if (dst_load !== x_dst) begin
      miscompares++;
      $display("FAIL %s dst_load cyc=%0d got=%h want=%h", tag, cyc, dst_load, x_dst);
    end
    vectors++;
    if (err !== x_err) begin
      miscompares++;
      $display("FAIL %s err cyc=%0d got=%b want=%b", tag, cyc, err, x_err);
    end
    if (ld && ref_legal(m_src)) begin
      vectors++;
      if (bus_contents !== mux_data[m_src]) begin
        miscompares++;
        $display("FAIL %s bus_contents cyc=%0d got=%h want=%h", tag, cyc, bus_contents,
                 mux_data[m_src]);
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    vectors++;
    if ({bus_select, dst_load, gnt, err, busy} !== '0) begin
      miscompares++;
      $display("FAIL %s outputs_zero got sel=%0d dst=%h gnt=%b err=%b busy=%b want all 0",
               tag, bus_select, dst_load, gnt, err, busy);
    end
  endtask

  task automatic do_reset(input string tag);
    req = '0;
    reset = 1'b1;
    #1;
    check_all_zero(tag);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset("reset");
    repeat (3) tick("reset_idle");
  endtask

  task automatic test_single();
    do_reset("single_rst");
    set_req(0, 5'd5, 5'd12);
    req = 4'b0001;
    tick("single");
    vectors++;
    if (bus_select !== 5'd5 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL single_c1 got sel=%0d busy=%b want sel=5 busy=1", bus_select, busy);
    end
    tick("single");
    vectors++;
    if (dst_load !== 32'h0000_1000 || gnt !== 4'b0001 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL single_c2 got dst=%h gnt=%b busy=%b want 00001000 0001 1",
               dst_load, gnt, busy);
    end
    req = '0;
    repeat (2) tick("single_tail");
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp;
    do_reset("rr_rst");
    for (int i = 0; i < N; i++) set_req(i, 5'(i + 1), 5'(i + 8));
    req = 4'b1111;
    for (int t = 1; t <= 15; t++) begin
      tick("rr");
      exp = '0;
      if (t % 3 == 2) exp[(t / 3) % N] = 1'b1;
      vectors++;
      if (gnt !== exp) begin
        miscompares++;
        $display("FAIL rr_order cyc=%0d got=%b want=%b", t, gnt, exp);
      end
    end
    req = '0;
    repeat (2) tick("rr_tail");
  endtask

  task automatic test_illegal();
    logic [4:0] srcs [2];
    srcs[0] = 5'd20;
    srcs[1] = 5'd31;
    do_reset("illegal_rst");
    for (int r = 0; r < 2; r++) begin
      set_req(2, srcs[r], 5'd3);
      req = 4'b0100;
      tick("illegal");
      tick("illegal");
      vectors++;
      if ({gnt, err, dst_load} !== {4'b0100, 1'b1, 32'h0}) begin
        miscompares++;
        $display("FAIL illegal_src%0d got gnt=%b err=%b dst=%h want 0100 1 0",
                 srcs[r], gnt, err, dst_load);
      end
      req = '0;
      tick("illegal_tail");
    end
  endtask

  task automatic test_drop();
    do_reset("drop_rst");
    set_req(1, 5'd7, 5'd7);
    req = 4'b0010;
    tick("drop");
    req = '0;
    set_req(1, 5'd0, 5'd0);
    tick("drop");
    vectors++;
    if (gnt !== 4'b0010 || dst_load !== 32'h0000_0080) begin
      miscompares++;
      $display("FAIL drop got gnt=%b dst=%h want 0010 00000080", gnt, dst_load);
    end
    repeat (2) tick("drop_tail");
  endtask

  task automatic test_reset_mid();
    do_reset("mid_rst0");
    set_req(0, 5'd3, 5'd6);
    req = 4'b0001;
    tick("mid");
    req = '0;
    reset = 1'b1;
    #1;
    check_all_zero("mid_async");
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    for (int t = 0; t < 6; t++) begin
      tick("mid_after");
      vectors++;
      if (gnt !== '0) begin
        miscompares++;
        $display("FAIL mid_no_gnt cyc=%0d got=%b want=0000", cyc, gnt);
      end
    end
  endtask

  task automatic test_data();
    do_reset("data_rst");
    set_req(0, 5'd9, 5'd4);
    req = 4'b0001;
    tick("data");
    tick("data");
    vectors++;
    if (dst_load !== 32'h0000_0010 || bus_contents !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL data got dst=%h bus=%h want 00000010 deadbeef", dst_load, bus_contents);
    end
    req = '0;
    tick("data_tail");
  endtask

  task automatic test_random();
    do_reset("rand_rst");
    for (int t = 0; t < 400; t++) begin
      req = N'($urandom);
      for (int i = 0; i < N; i++) begin
        set_req(i, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      end
      tick("rand");
    end
    req = '0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mux_data[i] = $urandom;
    mux_data[9] = 32'hDEAD_BEEF;
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_illegal();
    test_drop();
    test_reset_mid();
    test_data();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
